// File: rtl/serial_subtractor_64.sv
// Multi-cycle subtractor: diff = a - b - borrow_in, SLICE bits per clock, LSB slice first.
// Optional macro SUB_SAT_EN saturates diff on signed overflow.
module serial_subtractor_64 #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int          N       = WIDTH / SLICE;
    localparam int          CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SLICE_U = SLICE;

    // FIN is the single flag cycle between the last slice and DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               borrow_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   diff_raw_r;
    logic [WIDTH-1:0]   diff_r;
    logic               borrow_out_r;
    logic               ovf_r;
    logic               out_valid_r;
    logic               in_ready_r;

    logic [31:0]        shamt_s;
    logic [SLICE-1:0]   a_slice_s;
    logic [SLICE-1:0]   b_slice_s;
    logic [SLICE:0]     slice_res_s;
    logic               ovf_s;
    logic [WIDTH-1:0]   result_s;

    // Unsigned SLICE+1-bit subtraction; the top bit is the borrow out of the slice.
    function automatic logic [SLICE:0] sub_slice(
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y,
        input logic             bin
    );
        sub_slice = {1'b0, x} - {1'b0, y} - {{SLICE{1'b0}}, bin};
    endfunction

    // Current slice operands, slice result and end-of-operation flags.
    always_comb begin
        shamt_s     = 32'(cnt_r) * SLICE_U;
        a_slice_s   = SLICE'(a_r >> shamt_s);
        b_slice_s   = SLICE'(b_r >> shamt_s);
        slice_res_s = sub_slice(a_slice_s, b_slice_s, borrow_r);
        ovf_s       = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_raw_r[WIDTH-1] != a_r[WIDTH-1]);
`ifdef SUB_SAT_EN
        if (ovf_s) begin
            result_s = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            result_s = diff_raw_r;
        end
`else
        result_s = diff_raw_r;
`endif
    end

    // Control FSM, slice datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            borrow_r     <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            diff_raw_r   <= {WIDTH{1'b0}};
            diff_r       <= {WIDTH{1'b0}};
            borrow_out_r <= 1'b0;
            ovf_r        <= 1'b0;
            out_valid_r  <= 1'b0;
            in_ready_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= b;
                        borrow_r   <= borrow_in;
                        cnt_r      <= {CNT_W{1'b0}};
                        diff_raw_r <= {WIDTH{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= BUSY;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                BUSY: begin
                    in_ready_r <= 1'b0;
                    diff_raw_r <= diff_raw_r | (WIDTH'(slice_res_s[SLICE-1:0]) << shamt_s);
                    borrow_r   <= slice_res_s[SLICE];
                    cnt_r      <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(N - 1)) begin
                        state_r <= FIN;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                FIN: begin
                    diff_r       <= result_s;
                    borrow_out_r <= borrow_r;
                    ovf_r        <= ovf_s;
                    out_valid_r  <= 1'b1;
                    in_ready_r   <= 1'b0;
                    state_r      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                        state_r     <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_out_r;
    assign ovf        = ovf_r;

endmodule
